// File: rtl/alu8_issue_wb.sv
// alu8_issue_wb: issue/writeback stage around an external combinational 8-bit ALU.
// Build option ALU8_FWD_EN adds the EX/WB operand bypass; without it, hazards stall issue.
module alu8_issue_wb #(
    parameter int         ADDR_W    = 3,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_ra,
    input  logic [ADDR_W-1:0] in_rb,
    input  logic              in_imm_en,
    input  logic [7:0]        in_imm,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_s,
    input  logic [7:0]        alu_r,
    input  logic              alu_co,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [7:0]        wb_data,
    output logic              carry_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        rf [DEPTH];
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_rd;
    logic              wb_co;

    logic              accept;
    logic [7:0]        rf_a;
    logic [7:0]        rf_b;
    logic [7:0]        op_a;
    logic [7:0]        src_b;
    logic [7:0]        op_b;
    logic              ra_ex;
    logic              ra_wb;
    logic              rb_ex;
    logic              rb_wb;

    assign accept   = in_valid & in_ready;
    assign rf_a     = rf[in_ra];
    assign rf_b     = rf[in_rb];
    assign dbg_data = rf[dbg_addr];

    assign ra_ex = ex_valid && (ex_rd == in_ra);
    assign ra_wb = wb_valid && (wb_rd == in_ra);
    assign rb_ex = ex_valid && (ex_rd == in_rb);
    assign rb_wb = wb_valid && (wb_rd == in_rb);

`ifdef ALU8_FWD_EN
    // EX is younger than WB, so it takes priority when both hold the same rd.
    always_comb begin
        op_a = rf_a;
        if (ra_ex)
            op_a = alu_r;
        else if (ra_wb)
            op_a = wb_data;

        src_b = rf_b;
        if (rb_ex)
            src_b = alu_r;
        else if (rb_wb)
            src_b = wb_data;
    end

    assign in_ready = 1'b1;
`else
    logic hazard;

    // A WB match also stalls: the RF write lands on the same edge as the read would.
    assign hazard   = ra_ex | ra_wb | (~in_imm_en & (rb_ex | rb_wb));
    assign op_a     = rf_a;
    assign src_b    = rf_b;
    assign in_ready = ~hazard;
`endif

    assign op_b = in_imm_en ? in_imm : src_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_s      <= 3'd0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= 8'h00;
            wb_co      <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            ex_valid <= accept;
            if (accept) begin
                ex_rd <= in_rd;
                alu_a <= op_a;
                alu_b <= op_b;
                alu_s <= in_op;
            end

            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_rd   <= ex_rd;
                wb_data <= alu_r;
                wb_co   <= alu_co;
            end

            if (wb_valid)
                carry_flag <= wb_co;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rf <= '{default: RESET_VAL};
        else if (wb_valid)
            rf[wb_rd] <= wb_data;
    end

endmodule
